prog_updown_counter: RTL

//   Parametrised up/down counter for general-purpose counting and timing.

---
 rtl/prog_updown_counter.sv | 88 ++++++++
 1 files changed

// File: rtl/prog_updown_counter.sv
// Up/down counter with programmable modulo limit, wrap/saturate, load and prescaled enable.
// Drives a terminal-count pulse and a sticky wrap flag. All outputs are registered.
module prog_updown_counter #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  sat_mode,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clr_flag,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  wrapped
);

   logic [WIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic                  tc_q, tc_d;
   logic                  wrapped_q, wrapped_d;
   logic                  tick;
   logic                  boundary;

   always_comb begin
      tick      = en && (div_q == prescale);
      div_d     = div_q;
      count_d   = count_q;
      boundary  = 1'b0;
      if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
         div_d   = '0;
      end else begin
         if (en) begin
            div_d = tick ? '0 : div_q + PRESCALE_W'(1);
         end
         if (tick) begin
            if (up) begin
               if (count_q >= limit) begin
                  boundary = 1'b1;
                  count_d  = sat_mode ? limit : '0;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end else if (count_q > limit) begin
               // Out-of-range count after a limit change snaps back without an event.
               count_d = limit;
            end else if (count_q == '0) begin
               boundary = 1'b1;
               count_d  = sat_mode ? '0 : limit;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
      tc_d = boundary;
      if (boundary && !sat_mode) begin
         wrapped_d = 1'b1;
      end else if (clr_flag) begin
         wrapped_d = 1'b0;
      end else begin
         wrapped_d = wrapped_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         div_q     <= '0;
         tc_q      <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         div_q     <= div_d;
         tc_q      <= tc_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign wrapped = wrapped_q;

endmodule
